// File: rtl/udp_pkg.sv
// Shared types and helpers for the UDP transmit scheduler.
// Latency: n/a (package only).
// Backpressure: n/a.
package udp_pkg;

   localparam logic [15:0] UDP_PROTO     = 16'h0011;
   localparam int unsigned UDP_HDR_BYTES = 8;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_HDR0,
      ST_HDR1,
      ST_PAY
   } tx_state_t;

   // 16-bit one's-complement add: carry out of bit 15 wraps back into bit 0.
   // The wrapped result can never carry again because s[15:0] <= 16'hFFFE when s[16]=1.
   function automatic logic [15:0] oc_add16(input logic [15:0] a, input logic [15:0] b);
      logic [16:0] s;
      s = {1'b0, a} + {1'b0, b};
      return s[15:0] + {15'd0, s[16]};
   endfunction

endpackage

// File: rtl/udp_tx_sched_rr_arbiter.sv
// Rotating-priority arbiter: one-hot grant of the first requester at or after the pointer.
// Latency: grant is combinational from req; the pointer updates one cycle after advance.
// Backpressure: none; the caller decides when a grant is consumed by pulsing advance.
// Ports: clk, rst_n (async active-low), req[N], advance (consume current winner),
//        grant[N] (one-hot winner, zero when no request).
module rr_arbiter #(
   parameter int unsigned N = 2
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [N-1:0] req,
   input  logic         advance,
   output logic [N-1:0] grant
);

   localparam int unsigned PTR_W = (N > 1) ? $clog2(N) : 1;

   logic [PTR_W-1:0] ptr;
   logic [PTR_W-1:0] win;
   logic [PTR_W-1:0] k;
   logic             found;

   // Scan N positions starting at ptr, wrapping modulo N.
   always_comb begin
      grant = '0;
      win   = '0;
      k     = '0;
      found = 1'b0;
      for (int i = 0; i < N; i++) begin
         k = PTR_W'((32'(ptr) + 32'(i)) % N);
         if (!found && req[k]) begin
            found    = 1'b1;
            win      = k;
            grant[k] = 1'b1;
         end
      end
   end

   // Winner gets lowest priority next round.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr <= '0;
      end else if (advance && found) begin
         ptr <= (win == PTR_W'(N - 1)) ? '0 : win + 1'b1;
      end
   end

endmodule

// File: rtl/udp_tx_sched.sv
// Arbitrates payload producers, buffers one datagram while summing its checksum, then streams it.
// Latency: grant 1 cycle after req; first header word valid the cycle after the last payload accept.
// Backpressure: src_dval gaps stall LOAD indefinitely; out_ready low holds out_data/out_valid.
// Ports: clk, rst_n (async active-low); req/grant/src_data/src_dval/src_ready per source;
//        out_data/out_valid/out_last/out_ready toward the framer; busy = not IDLE.
module udp_tx_sched
   import udp_pkg::*;
#(
   parameter int unsigned N_SRC         = 2,
   parameter int unsigned PAYLOAD_WORDS = 3,
   parameter logic [15:0] SRC_IP        = 16'h0001,
   parameter logic [15:0] DST_IP        = 16'h0002,
   parameter logic [15:0] SRC_PORT      = 16'h1000,
   parameter logic [15:0] DST_PORT      = 16'h2000
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [N_SRC-1:0]    req,
   output logic [N_SRC-1:0]    grant,
   input  logic [N_SRC*32-1:0] src_data,
   input  logic [N_SRC-1:0]    src_dval,
   output logic [N_SRC-1:0]    src_ready,
   output logic [31:0]         out_data,
   output logic                out_valid,
   output logic                out_last,
   input  logic                out_ready,
   output logic                busy
);

   localparam int unsigned IDX_W    = (PAYLOAD_WORDS > 1) ? $clog2(PAYLOAD_WORDS) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PAYLOAD_WORDS - 1);
   localparam logic [15:0] UDP_LEN  = 16'(UDP_HDR_BYTES + 4 * PAYLOAD_WORDS);
   // Pseudo-header plus the fixed UDP header fields; UDP_LEN appears twice
   // (once in the pseudo-header, once in the UDP header itself).
   localparam logic [15:0] CSUM_SEED =
      oc_add16(oc_add16(oc_add16(oc_add16(oc_add16(oc_add16(
         SRC_IP, DST_IP), UDP_PROTO), UDP_LEN), SRC_PORT), DST_PORT), UDP_LEN);

   tx_state_t         state, state_nxt;
   logic [N_SRC-1:0]  grant_q;
   logic [N_SRC-1:0]  arb_grant;
   logic              arb_advance;
   logic [IDX_W-1:0]  idx;
   logic [15:0]       acc;
   logic [15:0]       csum;
   logic [31:0]       sel_data;
   logic              accept;
   logic              xfer;
   logic [31:0]       pay_buf [PAYLOAD_WORDS];

   assign arb_advance = (state == ST_IDLE) && (|req);

   rr_arbiter #(.N(N_SRC)) u_arb (
      .clk     (clk),
      .rst_n   (rst_n),
      .req     (req),
      .advance (arb_advance),
      .grant   (arb_grant)
   );

   // grant_q is one-hot, so an OR-mux picks the granted source's word.
   always_comb begin
      sel_data = '0;
      for (int i = 0; i < N_SRC; i++) begin
         if (grant_q[i]) sel_data = sel_data | src_data[32*i +: 32];
      end
   end

   assign accept = |(src_dval & src_ready);
   assign xfer   = out_valid & out_ready;
   assign csum   = (~acc == 16'h0000) ? 16'hFFFF : ~acc;
   assign grant  = grant_q;

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_nxt;
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      unique case (state)
         ST_IDLE: if (|req)                      state_nxt = ST_LOAD;
         ST_LOAD: if (accept && idx == LAST_IDX) state_nxt = ST_HDR0;
         ST_HDR0: if (xfer)                      state_nxt = ST_HDR1;
         ST_HDR1: if (xfer)                      state_nxt = ST_PAY;
         ST_PAY:  if (xfer && idx == LAST_IDX)   state_nxt = ST_IDLE;
         default:                                state_nxt = ST_IDLE;
      endcase
   end

   // Output logic: purely a function of state and held registers, so it is
   // stable while out_ready is low and clears the instant reset asserts.
   always_comb begin
      src_ready = '0;
      out_valid = 1'b0;
      out_last  = 1'b0;
      out_data  = '0;
      busy      = (state != ST_IDLE);
      unique case (state)
         ST_LOAD: src_ready = grant_q;
         ST_HDR0: begin
            out_valid = 1'b1;
            out_data  = {SRC_PORT, DST_PORT};
         end
         ST_HDR1: begin
            out_valid = 1'b1;
            out_data  = {UDP_LEN, csum};
         end
         ST_PAY: begin
            out_valid = 1'b1;
            out_data  = pay_buf[idx];
            out_last  = (idx == LAST_IDX);
         end
         default: ;
      endcase
   end

   // Datapath: grant, word index, checksum accumulator, payload buffer.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         grant_q <= '0;
         idx     <= '0;
         acc     <= '0;
         for (int i = 0; i < PAYLOAD_WORDS; i++) pay_buf[i] <= '0;
      end else begin
         unique case (state)
            ST_IDLE: begin
               acc <= CSUM_SEED;
               idx <= '0;
               if (|req) grant_q <= arb_grant;
            end
            ST_LOAD: begin
               if (accept) begin
                  pay_buf[idx] <= sel_data;
                  acc <= oc_add16(oc_add16(acc, sel_data[31:16]), sel_data[15:0]);
                  if (idx == LAST_IDX) begin
                     idx     <= '0;
                     grant_q <= '0;
                  end else begin
                     idx <= idx + 1'b1;
                  end
               end
            end
            ST_PAY: begin
               if (xfer) idx <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_udp_tx_sched.sv
module tb_udp_tx_sched;
   import udp_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [1:0]  req;
   logic [1:0]  grant;
   logic [63:0] src_data;
   logic [1:0]  src_dval;
   logic [1:0]  src_ready;
   logic [31:0] out_data;
   logic        out_valid;
   logic        out_last;
   logic        out_ready;
   logic        busy;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   udp_tx_sched #(
      .N_SRC         (2),
      .PAYLOAD_WORDS (1)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req       (req),
      .grant     (grant),
      .src_data  (src_data),
      .src_dval  (src_dval),
      .src_ready (src_ready),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_last  (out_last),
      .out_ready (out_ready),
      .busy      (busy)
   );

   typedef struct {
      logic [1:0]  req_v;
      int          src;
      logic [31:0] pay;
      logic [31:0] exp_h1;
   } vec_t;

   vec_t vecs[5];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // One full datagram: request, load one word, collect three output words.
   // stall>0 holds out_ready low for that many cycles while HDR1 is presented.
   task automatic run_pkt(input logic [1:0] req_v, input int src,
                          input logic [31:0] pay0, input logic [31:0] pay1,
                          input logic [31:0] exp_h1, input int stall, input bit hold_req);
      logic [31:0] got [3];
      logic        lst [3];
      int          n;
      int          cyc;
      logic [1:0]  exp_g;
      logic [31:0] exp_p;
      exp_g = 2'b01 << src;
      exp_p = (src == 0) ? pay0 : pay1;
      for (int i = 0; i < 3; i++) begin
         got[i] = 'x;
         lst[i] = 1'bx;
      end
      req = req_v;
      cyc = 0;
      do begin
         @(negedge clk);
         cyc++;
      end while (grant == 2'b00 && cyc < 20);
      chk("grant", {30'd0, grant}, {30'd0, exp_g});
      if (!hold_req) req = 2'b00;
      src_data = {pay1, pay0};
      src_dval = req_v;
      chk("src_ready", {30'd0, src_ready}, {30'd0, exp_g});
      @(negedge clk);
      src_dval = 2'b00;
      chk("grant_drop", {30'd0, grant}, 32'd0);
      chk("busy_hi", {31'd0, busy}, 32'd1);
      n = 0;
      cyc = 0;
      out_ready = 1'b1;
      while (n < 3 && cyc < 40) begin
         if (out_valid) begin
            if (n == 1 && stall > 0) begin
               out_ready = 1'b0;
               stall--;
               chk("hold_dat", out_data, exp_h1);
            end else begin
               out_ready = 1'b1;
               got[n] = out_data;
               lst[n] = out_last;
               n++;
            end
         end
         @(negedge clk);
         cyc++;
      end
      chk("word_cnt", n, 32'd3);
      chk("hdr0", got[0], 32'h1000_2000);
      chk("hdr1", got[1], exp_h1);
      chk("payload", got[2], exp_p);
      chk("last_bits", {29'd0, lst[0], lst[1], lst[2]}, 32'd1);
      chk("busy_lo", {31'd0, busy}, 32'd0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      vecs[0] = '{2'b01, 0, 32'h0000_0000, 32'h000C_CFD3};
      vecs[1] = '{2'b10, 1, 32'hFFFF_FFFF, 32'h000C_CFD3};
      vecs[2] = '{2'b01, 0, 32'h0000_CFD3, 32'h000C_FFFF};
      vecs[3] = '{2'b10, 1, 32'h1234_5678, 32'h000C_6727};
      vecs[4] = '{2'b01, 0, 32'h8000_8000, 32'h000C_CFD2};

      rst_n     = 1'b0;
      req       = 2'b00;
      src_data  = '0;
      src_dval  = 2'b00;
      out_ready = 1'b1;
      #12;
      chk("rst_grant",  {30'd0, grant},     32'd0);
      chk("rst_ready",  {30'd0, src_ready}, 32'd0);
      chk("rst_valid",  {31'd0, out_valid}, 32'd0);
      chk("rst_last",   {31'd0, out_last},  32'd0);
      chk("rst_data",   out_data,           32'd0);
      chk("rst_busy",   {31'd0, busy},      32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Single-source datagrams with hand-computed checksums.
      for (int v = 0; v < 5; v++)
         run_pkt(vecs[v].req_v, vecs[v].src, vecs[v].pay, vecs[v].pay, vecs[v].exp_h1, 0, 1'b0);

      // Backpressure held for 3 cycles on the second header word.
      run_pkt(2'b01, 0, 32'h1234_5678, 32'h0, 32'h000C_6727, 3, 1'b0);

      // Both sources requesting continuously: grants alternate from pointer 0.
      do_reset();
      run_pkt(2'b11, 0, 32'h0000_0000, 32'h1234_5678, 32'h000C_CFD3, 0, 1'b1);
      run_pkt(2'b11, 1, 32'h0000_0000, 32'h1234_5678, 32'h000C_6727, 0, 1'b1);
      run_pkt(2'b11, 0, 32'h0000_0000, 32'h1234_5678, 32'h000C_CFD3, 0, 1'b0);

      // Reset asserted while the payload word is being presented.
      req = 2'b01;
      begin
         int cyc = 0;
         do begin
            @(negedge clk);
            cyc++;
         end while (grant == 2'b00 && cyc < 20);
      end
      chk("mp_grant", {30'd0, grant}, 32'd1);
      req      = 2'b00;
      src_data = {32'h0, 32'hDEAD_BEEF};
      src_dval = 2'b01;
      @(negedge clk);
      src_dval  = 2'b00;
      out_ready = 1'b1;
      @(negedge clk);
      @(negedge clk);
      out_ready = 1'b0;
      chk("mp_in_pay", {31'd0, out_last}, 32'd1);
      chk("mp_pay_dat", out_data, 32'hDEAD_BEEF);
      #2 rst_n = 1'b0;
      #1;
      chk("mp_valid", {31'd0, out_valid}, 32'd0);
      chk("mp_last",  {31'd0, out_last},  32'd0);
      chk("mp_data",  out_data,           32'd0);
      chk("mp_busy",  {31'd0, busy},      32'd0);
      chk("mp_grant0", {30'd0, grant},    32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      out_ready = 1'b1;
      run_pkt(2'b01, 0, 32'h0000_0000, 32'h0, 32'h000C_CFD3, 0, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
